// File: rtl/regfile_inject_writer_if.sv
`default_nettype none
// ============================================================================
//  Module   : regfile_inject_writer_if
//  Purpose  : Bundles the three buses around the register-file inject writer:
//             the processor writeback, the peripheral request channel, and
//             the merged register-file write port plus status.
//  Modports : slave  - the inject writer itself
//             master - whatever drives writeback/requests and watches the
//                      register-file port (top level or testbench)
//  Revision : 1.0 - initial release
// ============================================================================
interface regfile_inject_writer_if #(
  parameter int DEPTH = 4
) ();
  // Processor writeback
  logic                    cpu_we;
  logic [4:0]              cpu_rd;
  logic [31:0]             cpu_data;
  logic                    cpu_stall;
  // Peripheral request channel
  logic                    req_valid;
  logic [4:0]              req_reg;
  logic [31:0]             req_data;
  logic                    req_ready;
  logic                    err_clear;
  // Register-file write port and status
  logic                    ctrl_writeEnable;
  logic [4:0]              ctrl_writeReg;
  logic [31:0]             data_writeReg;
  logic [$clog2(DEPTH):0]  pending_count;
  logic                    err_range;

  modport slave (
    input  cpu_we, cpu_rd, cpu_data, req_valid, req_reg, req_data, err_clear,
    output cpu_stall, req_ready, ctrl_writeEnable, ctrl_writeReg,
           data_writeReg, pending_count, err_range
  );

  modport master (
    output cpu_we, cpu_rd, cpu_data, req_valid, req_reg, req_data, err_clear,
    input  cpu_stall, req_ready, ctrl_writeEnable, ctrl_writeReg,
           data_writeReg, pending_count, err_range
  );
endinterface
`default_nettype wire

// File: rtl/regfile_inject_writer.sv
`default_nettype none
// ============================================================================
//  Module   : regfile_inject_writer
//  Purpose  : Write path from hardware peripherals back into the processor
//             register file. Peripheral requests are queued in a small FIFO
//             and merged onto the single register-file write port in cycles
//             where processor writeback leaves it idle. Writeback always wins.
//  Ports    : clock      - system clock, rising edge
//             ctrl_reset - asynchronous, active-high reset
//             bus        - regfile_inject_writer_if.slave (writeback in,
//                          request channel, register-file port, status)
//  Options  : `define REGFILE_INJECT_STARVE_GUARD_EN enables the starvation
//             guard (cpu_stall); otherwise cpu_stall is tied low.
//  Revision : 1.0 - initial release
// ============================================================================
module regfile_inject_writer #(
  parameter int DEPTH        = 4,
  parameter int REG_LO       = 25,
  parameter int REG_HI       = 29,
  parameter int STARVE_LIMIT = 8
) (
  input  wire logic              clock,
  input  wire logic              ctrl_reset,
  regfile_inject_writer_if.slave bus
);

  localparam int         c_PTR_W  = $clog2(DEPTH);
  localparam int         c_CNT_W  = c_PTR_W + 1;
  localparam logic [4:0] c_REG_LO = 5'(REG_LO);
  localparam logic [4:0] c_REG_HI = 5'(REG_HI);

  // Elaboration-time parameter sanity guard.
  if (DEPTH < 2 || DEPTH > 16 || (DEPTH & (DEPTH - 1)) != 0 ||
      STARVE_LIMIT < 1) begin : g_badParams
    $error("regfile_inject_writer: illegal DEPTH or STARVE_LIMIT");
  end

  // --------------------------------------------------------------------------
  // FIFO storage and bookkeeping
  // --------------------------------------------------------------------------
  logic [4:0]         r_fifoReg  [DEPTH];
  logic [31:0]        r_fifoData [DEPTH];
  logic [c_PTR_W-1:0] r_wrPtr;
  logic [c_PTR_W-1:0] r_rdPtr;
  logic [c_CNT_W-1:0] r_count;
  logic               r_errRange;

  logic w_full;
  logic w_empty;
  logic w_ready;
  logic w_accept;
  logic w_inRange;
  logic w_push;
  logic w_rangeErr;
  logic w_pop;

  assign w_full  = (r_count == c_CNT_W'(DEPTH));
  assign w_empty = (r_count == '0);

  // Ready comes from the pre-pop count: a full FIFO never accepts, even if
  // it drains an entry on the same edge. Held low throughout reset.
  assign w_ready  = !w_full && !ctrl_reset;
  assign w_accept = bus.req_valid && w_ready;

  assign w_inRange  = (bus.req_reg >= c_REG_LO) && (bus.req_reg <= c_REG_HI) &&
                      (bus.req_reg != 5'd0);
  // Out-of-range requests complete the handshake but are dropped.
  assign w_push     = w_accept && w_inRange;
  assign w_rangeErr = w_accept && !w_inRange;

  // The head only drains when writeback leaves the port free.
  assign w_pop = !bus.cpu_we && !w_empty && !ctrl_reset;

  always_ff @(posedge clock) begin
    if (w_push) begin
      r_fifoReg[r_wrPtr]  <= bus.req_reg;
      r_fifoData[r_wrPtr] <= bus.req_data;
    end
  end

  always_ff @(posedge clock or posedge ctrl_reset) begin
    if (ctrl_reset) begin
      r_wrPtr    <= '0;
      r_rdPtr    <= '0;
      r_count    <= '0;
      r_errRange <= 1'b0;
    end else begin
      // Pointers wrap naturally: DEPTH is a power of two.
      if (w_push) r_wrPtr <= r_wrPtr + 1'b1;
      if (w_pop)  r_rdPtr <= r_rdPtr + 1'b1;

      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase

      // A new error wins over a simultaneous clear.
      if (w_rangeErr)         r_errRange <= 1'b1;
      else if (bus.err_clear) r_errRange <= 1'b0;
    end
  end

  // --------------------------------------------------------------------------
  // Register-file port mux (combinational, zero latency). No empty-FIFO
  // bypass: a freshly accepted request shows up one cycle later at best.
  // --------------------------------------------------------------------------
  always_comb begin
    bus.ctrl_writeEnable = 1'b0;
    bus.ctrl_writeReg    = 5'd0;
    bus.data_writeReg    = 32'd0;
    if (!ctrl_reset) begin
      if (bus.cpu_we) begin
        bus.ctrl_writeEnable = 1'b1;
        bus.ctrl_writeReg    = bus.cpu_rd;
        bus.data_writeReg    = bus.cpu_data;
      end else if (!w_empty) begin
        bus.ctrl_writeEnable = 1'b1;
        bus.ctrl_writeReg    = r_fifoReg[r_rdPtr];
        bus.data_writeReg    = r_fifoData[r_rdPtr];
      end
    end
  end

  assign bus.req_ready     = w_ready;
  assign bus.pending_count = r_count;
  assign bus.err_range     = r_errRange;

  // --------------------------------------------------------------------------
  // Starvation guard
  // --------------------------------------------------------------------------
`ifdef REGFILE_INJECT_STARVE_GUARD_EN
  localparam int c_STARVE_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [c_STARVE_W-1:0] c_STARVE_MAX = c_STARVE_W'(STARVE_LIMIT);

  logic [c_STARVE_W-1:0] r_starveCnt;

  // Counts cycles the head has been blocked by writeback; saturates at the
  // limit so the stall request holds until the processor yields a cycle.
  always_ff @(posedge clock or posedge ctrl_reset) begin
    if (ctrl_reset) begin
      r_starveCnt <= '0;
    end else if (w_pop || w_empty) begin
      r_starveCnt <= '0;
    end else if (bus.cpu_we && (r_starveCnt != c_STARVE_MAX)) begin
      r_starveCnt <= r_starveCnt + 1'b1;
    end
  end

  assign bus.cpu_stall = (r_starveCnt == c_STARVE_MAX) && !ctrl_reset;
`else
  assign bus.cpu_stall = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_regfile_inject_writer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_regfile_inject_writer
//  Purpose  : Self-checking bench for regfile_inject_writer. A queue-based
//             reference model predicts the register-file port and status
//             every cycle; directed scenarios are followed by random traffic.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_inject_writer;

  localparam int DEPTH        = 4;
  localparam int STARVE_LIMIT = 8;

  logic clock;
  logic ctrl_reset;

  regfile_inject_writer_if #(.DEPTH(DEPTH)) bus ();

  regfile_inject_writer #(
    .DEPTH(DEPTH), .REG_LO(25), .REG_HI(29), .STARVE_LIMIT(STARVE_LIMIT)
  ) dut (
    .clock(clock),
    .ctrl_reset(ctrl_reset),
    .bus(bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int nChecks = 0;
  int nErrors = 0;

  // Reference model state
  logic [4:0]  mReg[$];
  logic [31:0] mData[$];
  bit          mErr  = 1'b0;
  int          mWait = 0;

  task automatic checkVal(input string tag, input logic [31:0] obs,
                          input logic [31:0] exp);
    nChecks++;
    if (obs !== exp) begin
      nErrors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit modelStall();
`ifdef REGFILE_INJECT_STARVE_GUARD_EN
    return mWait >= STARVE_LIMIT;
`else
    return 1'b0;
`endif
  endfunction

  task automatic modelReset();
    mReg.delete();
    mData.delete();
    mErr  = 1'b0;
    mWait = 0;
  endtask

  // One clock cycle: entered and left at a falling edge.
  task automatic stepCycle(input logic we, input logic [4:0] rd,
                           input logic [31:0] cd, input logic rv,
                           input logic [4:0] rr, input logic [31:0] rdat,
                           input logic ec);
    logic        expWe;
    logic [4:0]  expReg;
    logic [31:0] expData;
    bit          expReady, doAccept, doPop, badReg;
    int          sizeNow;
    bus.cpu_we    = we;
    bus.cpu_rd    = rd;
    bus.cpu_data  = cd;
    bus.req_valid = rv;
    bus.req_reg   = rr;
    bus.req_data  = rdat;
    bus.err_clear = ec;
    #1;
    sizeNow  = mReg.size();
    expReady = sizeNow < DEPTH;
    if (we) begin
      expWe = 1'b1; expReg = rd; expData = cd;
    end else if (sizeNow > 0) begin
      expWe = 1'b1; expReg = mReg[0]; expData = mData[0];
    end else begin
      expWe = 1'b0; expReg = 5'd0; expData = 32'd0;
    end
    checkVal("writeEnable", 32'(bus.ctrl_writeEnable), 32'(expWe));
    checkVal("writeReg",    32'(bus.ctrl_writeReg),    32'(expReg));
    checkVal("writeData",   bus.data_writeReg,         expData);
    checkVal("reqReady",    32'(bus.req_ready),        32'(expReady));
    checkVal("pending",     32'(bus.pending_count),    32'(sizeNow));
    checkVal("errRange",    32'(bus.err_range),        32'(mErr));
    checkVal("cpuStall",    32'(bus.cpu_stall),        32'(modelStall()));
    @(posedge clock);
    doAccept = rv && expReady;
    doPop    = !we && sizeNow > 0;
    badReg   = (rr < 5'd25) || (rr > 5'd29);
    if (doPop || sizeNow == 0) mWait = 0;
    else if (we)               mWait++;
    if (doPop) begin
      void'(mReg.pop_front());
      void'(mData.pop_front());
    end
    if (doAccept && !badReg) begin
      mReg.push_back(rr);
      mData.push_back(rdat);
    end
    if (doAccept && badReg) mErr = 1'b1;
    else if (ec)            mErr = 1'b0;
    @(negedge clock);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) stepCycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0);
  endtask

  initial begin
    ctrl_reset    = 1'b1;
    bus.cpu_we    = 1'b1;
    bus.cpu_rd    = 5'd5;
    bus.cpu_data  = 32'h11;
    bus.req_valid = 1'b1;
    bus.req_reg   = 5'd26;
    bus.req_data  = 32'h1;
    bus.err_clear = 1'b0;
    #3;
    // Reset held: port and ready forced low even with writeback active
    checkVal("rstWriteEnable", 32'(bus.ctrl_writeEnable), 32'd0);
    checkVal("rstWriteReg",    32'(bus.ctrl_writeReg),    32'd0);
    checkVal("rstWriteData",   bus.data_writeReg,         32'd0);
    checkVal("rstReady",       32'(bus.req_ready),        32'd0);
    checkVal("rstStall",       32'(bus.cpu_stall),        32'd0);
    repeat (2) @(negedge clock);
    ctrl_reset = 1'b0;
    modelReset();

    // Idle after reset release
    idle(2);

    // Single inject: no bypass, written next cycle
    stepCycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd26, 32'hDEADBEEF, 1'b0);
    idle(2);

    // Priority and fill: fifth request refused while full
    stepCycle(1'b1, 5'd5, 32'h11, 1'b1, 5'd25, 32'hA0, 1'b0);
    stepCycle(1'b1, 5'd5, 32'h11, 1'b1, 5'd26, 32'hA1, 1'b0);
    stepCycle(1'b1, 5'd5, 32'h11, 1'b1, 5'd27, 32'hA2, 1'b0);
    stepCycle(1'b1, 5'd5, 32'h11, 1'b1, 5'd28, 32'hA3, 1'b0);
    stepCycle(1'b1, 5'd5, 32'h11, 1'b1, 5'd29, 32'hA4, 1'b0);
    stepCycle(1'b1, 5'd0, 32'h22, 1'b0, 5'd0,  32'h0,  1'b0);
    idle(5);

    // Range errors, then a clear
    stepCycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 32'h33, 1'b0);
    stepCycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h44, 1'b0);
    idle(1);
    // Error and clear together: error wins
    stepCycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd30, 32'h55, 1'b1);
    stepCycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'h0, 1'b1);
    idle(1);

    // Reset mid-drain
    stepCycle(1'b1, 5'd7, 32'h77, 1'b1, 5'd25, 32'hB0, 1'b0);
    stepCycle(1'b1, 5'd7, 32'h77, 1'b1, 5'd26, 32'hB1, 1'b0);
    stepCycle(1'b1, 5'd7, 32'h77, 1'b1, 5'd27, 32'hB2, 1'b0);
    bus.cpu_we    = 1'b0;
    bus.req_valid = 1'b0;
    #1;
    checkVal("drainHeadWe",  32'(bus.ctrl_writeEnable), 32'd1);
    checkVal("drainHeadReg", 32'(bus.ctrl_writeReg),    32'd25);
    #2 ctrl_reset = 1'b1;
    #1;
    checkVal("midRstWe",      32'(bus.ctrl_writeEnable), 32'd0);
    checkVal("midRstPending", 32'(bus.pending_count),    32'd0);
    @(posedge clock);
    @(negedge clock);
    ctrl_reset = 1'b0;
    modelReset();
    idle(3);

`ifdef REGFILE_INJECT_STARVE_GUARD_EN
    // Starvation: one entry blocked by continuous writeback
    stepCycle(1'b1, 5'd9, 32'h99, 1'b1, 5'd28, 32'hC0, 1'b0);
    for (int i = 0; i < STARVE_LIMIT + 2; i++)
      stepCycle(1'b1, 5'd9, 32'h99, 1'b0, 5'd0, 32'h0, 1'b0);
    stepCycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'h0, 1'b0);
    stepCycle(1'b1, 5'd9, 32'h99, 1'b0, 5'd0, 32'h0, 1'b0);
`endif

    // Random traffic, mostly in-range targets
    for (int i = 0; i < 400; i++) begin
      logic we;
      logic [4:0] rr;
      we = 1'($urandom_range(0, 1));
      if (modelStall()) we = 1'b0;
      rr = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31))
                                       : 5'($urandom_range(25, 29));
      stepCycle(we, 5'($urandom), $urandom, 1'($urandom_range(0, 1)), rr,
                $urandom, ($urandom_range(0, 7) == 0));
    end
    idle(6);

    $display("CHECKS %0d ERRORS %0d", nChecks, nErrors);
    $finish;
  end

endmodule
`default_nettype wire
